timestamp_capture: RTL and testbench
====================================

Name: timestamp_capture

Overview:
- Free-running pWIDTH-bit timebase with pCHANNELS independent capture channels.
- Each asynchronous latch input is synchronised and edge-detected. On the detected edge, the current count is captured into a per-channel holding register and a ready flag is raised.
- Host acknowledges per channel. Overrun is flagged, and the captured timestamp of one selected channel is muxed out.
- Sits between external event pins and the host readout logic. It is the multi-channel, synchronised successor of the two-channel latch counter.

Parameters:
- pWIDTH, 64, counter and timestamp width (>=2).
- pCHANNELS, 4, number of capture channels (1..32).
- pSYNC_STAGES, 2, synchroniser flops per latch input (>=2).
- pOVERWRITE, 0, 0 = keep the first timestamp on overrun; 1 = replace it with the newest.

Ports:
- iCLK  in  1  single clock for all logic.
- iRST_N  in  1  asynchronous, active-low reset.
- iCntEn  in  1  counter increments when high.
- iCntClr  in  1  synchronous counter clear.
- iLatch  in  pCHANNELS  asynchronous event inputs; a rising edge triggers capture.
- iAck  in  pCHANNELS  per-channel acknowledge; single-cycle pulse.
- iSel  in  SEL_W  readout channel select.
- oCount  out  pWIDTH  live counter value.
- oData  out  pWIDTH  held timestamp of the channel selected by iSel.
- oRdy  out  pCHANNELS  per-channel capture-valid flag.
- oOvr  out  pCHANNELS  per-channel sticky overrun flag.
- oWrap  out  1  sticky counter-wrap flag.

Behaviour:
- Reset (iRST_N low, asynchronous): counter, all sync/prev flops, hold registers, oRdy, oOvr and oWrap go to 0.
- Counter:
  - iCntClr=1: count <= 0 and oWrap <= 0. iCntClr overrides iCntEn.
  - Otherwise, iCntEn=1: count <= count+1 modulo 2^pWIDTH. The transition all-ones -> 0 sets oWrap.
  - oCount is the register output directly.
- Synchroniser: a pSYNC_STAGES flop chain per channel, followed by a prev flop. Edge = sync_out & ~prev.
- Capture timing: the input is first sampled high at edge T; edge is asserted during the cycle after edge T+pSYNC_STAGES-1. At edge T+pSYNC_STAGES:
  - the hold register loads the count present in that cycle, i.e. count after edge T+pSYNC_STAGES-1;
  - oRdy rises.
- Latency rule: timestamp = count(T) + pSYNC_STAGES-1 when iCntEn is held high. Latency is fixed and is not compensated.
- Per-channel update priority (one clock):
  1. Ack and edge both high: capture the new value, oRdy stays 1, oOvr <= 0 (ack applies first, then capture).
  2. Ack only: oRdy <= 0, oOvr <= 0; the hold register keeps its value.
  3. Edge with oRdy=0: capture, oRdy <= 1.
  4. Edge with oRdy=1: oOvr <= 1. The hold register is replaced only if pOVERWRITE=1.
- Ack while oRdy=0: oOvr is cleared; nothing else changes.
- Edge in the same cycle as iCntClr: captures the pre-clear count.
- Input held high through reset release: produces exactly one capture (sync/prev reset to 0).
- Held input level: no retrigger until the input goes low for at least one synchronised sample and rises again.
- Readout:
  - oData = hold[iSel], combinational, zero latency.
  - iSel >= pCHANNELS gives oData = 0.
  - Reading does not clear oRdy.
- Channels are fully independent. Simultaneous edges on any set of channels all capture the same count.
- Pulses shorter than one iCLK period may be missed; this is not flagged.

Decomposition:
- Package timestamp_capture_pkg:
  - SEL_W = pCHANNELS>1 ? $clog2(pCHANNELS) : 1, as a function of pCHANNELS;
  - parameter defaults;
  - the overwrite-mode constants KEEP_FIRST=0 and KEEP_LAST=1.
- Sub-module ts_capture_channel: synchroniser, edge detect, hold register, rdy/ovr logic. Parameters pWIDTH, pSYNC_STAGES, pOVERWRITE. Instantiated pCHANNELS times.
- Counter, wrap flag and readout mux live in the top level.

Test Plan:
1. Reset, then iCntEn=1; count=100 after edge T, iLatch[0] rises before edge T -> at edge T+2: oRdy[0]=1; iSel=0 gives oData=101; oOvr[0]=0.
2. Second iLatch[0] rise while oRdy[0]=1, pOVERWRITE=0 -> oOvr[0]=1 and oData still 101. Repeat with pOVERWRITE=1 -> oData equals the new timestamp. A later iAck[0] pulse clears oRdy[0] and oOvr[0] in one cycle.
3. iAck[1] in the same cycle that edge[1] is asserted, with oRdy[1]=1 -> oRdy[1] stays 1, hold[1] = new count, oOvr[1]=0.
4. Force count to 2^64-2 via iCntEn, advance 2 cycles -> count=0, oWrap=1. Pulse iCntClr -> oWrap=0. iCntClr and iCntEn high together -> count=0.
5. iLatch[0..3] rise on the same edge -> all four oRdy set together and all hold values equal. iSel=5 with pCHANNELS=4 and SEL_W=3 -> oData=0.
6. iLatch[2] held high across deassertion of iRST_N -> exactly one capture on channel 2. Assert iRST_N mid-operation -> all outputs 0 immediately, without waiting for iCLK.

Source files
------------

// File: rtl/timestamp_capture_pkg.sv
// Shared defaults, overwrite-mode constants and per-channel action type for
// the multi-channel timestamp capture block.
package timestamp_capture_pkg;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int KEEP_FIRST    = 0;
  localparam int KEEP_LAST     = 1;
  localparam int DEF_OVERWRITE = KEEP_FIRST;

  // Resolved per-cycle action of one channel, in priority order.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_ACK_CAPTURE,
    ACT_ACK,
    ACT_CAPTURE,
    ACT_OVERRUN
  } ch_action_e;

  function automatic int sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/ts_capture_channel.sv
// One capture channel: input synchroniser, rising-edge detect, holding
// register and ready/overrun flags.
module ts_capture_channel
  import timestamp_capture_pkg::*;
#(
  parameter int pWIDTH       = DEF_WIDTH,
  parameter int pSYNC_STAGES = DEF_SYNC_STAGES,
  parameter int pOVERWRITE   = DEF_OVERWRITE
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLatch,
  input  logic              iAck,
  input  logic [pWIDTH-1:0] iCount,
  output logic [pWIDTH-1:0] oHold,
  output logic              oRdy,
  output logic              oOvr
);

  logic [pSYNC_STAGES-1:0] sync_q;
  logic                    prev_q;
  logic                    edge_det;
  logic [pWIDTH-1:0]       hold_q, hold_d;
  logic                    rdy_q, rdy_d;
  logic                    ovr_q, ovr_d;
  ch_action_e              action;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[pSYNC_STAGES-2:0], iLatch};
      prev_q <= sync_q[pSYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[pSYNC_STAGES-1] & ~prev_q;

  always_comb begin
    if (iAck && edge_det)      action = ACT_ACK_CAPTURE;
    else if (iAck)             action = ACT_ACK;
    else if (edge_det && !rdy_q) action = ACT_CAPTURE;
    else if (edge_det)         action = ACT_OVERRUN;
    else                       action = ACT_IDLE;
  end

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    hold_d = hold_q;
    rdy_d  = rdy_q;
    ovr_d  = ovr_q;
    case (action)
      ACT_ACK_CAPTURE: begin
        hold_d = iCount;
        rdy_d  = 1'b1;
        ovr_d  = 1'b0;
      end
      ACT_ACK: begin
        rdy_d = 1'b0;
        ovr_d = 1'b0;
      end
      ACT_CAPTURE: begin
        hold_d = iCount;
        rdy_d  = 1'b1;
      end
      ACT_OVERRUN: begin
        ovr_d = 1'b1;
        if (pOVERWRITE == KEEP_LAST) hold_d = iCount;
      end
      default: ;
    endcase
  end

  // NOTE: the holding register is reset too, so a host reading before the
  // first capture sees a defined zero rather than power-up garbage.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hold_q <= '0;
      rdy_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rdy_q  <= rdy_d;
      ovr_q  <= ovr_d;
    end
  end

  assign oHold = hold_q;
  assign oRdy  = rdy_q;
  assign oOvr  = ovr_q;

endmodule

// File: rtl/timestamp_capture.sv
// Free-running timebase with pCHANNELS synchronised capture channels, a
// sticky wrap flag and a combinational readout mux.
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int pWIDTH       = DEF_WIDTH,
  parameter int pCHANNELS    = DEF_CHANNELS,
  parameter int pSYNC_STAGES = DEF_SYNC_STAGES,
  parameter int pOVERWRITE   = DEF_OVERWRITE,
  parameter int SEL_W        = sel_w(pCHANNELS)
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iCntEn,
  input  logic                 iCntClr,
  input  logic [pCHANNELS-1:0] iLatch,
  input  logic [pCHANNELS-1:0] iAck,
  input  logic [SEL_W-1:0]     iSel,
  output logic [pWIDTH-1:0]    oCount,
  output logic [pWIDTH-1:0]    oData,
  output logic [pCHANNELS-1:0] oRdy,
  output logic [pCHANNELS-1:0] oOvr,
  output logic                 oWrap
);

  logic [pWIDTH-1:0] count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [pWIDTH-1:0] hold [pCHANNELS];

  // Clear wins over enable; wrap is raised only on the all-ones -> 0 step.
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (iCntClr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (iCntEn) begin
      count_d = count_q + pWIDTH'(1);
      if (&count_q) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Channels see the pre-update count, so a capture coinciding with a clear
  // still records the old value.
  for (genvar g = 0; g < pCHANNELS; g++) begin : g_ch
    ts_capture_channel #(
      .pWIDTH      (pWIDTH),
      .pSYNC_STAGES(pSYNC_STAGES),
      .pOVERWRITE  (pOVERWRITE)
    ) u_ch (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .iLatch(iLatch[g]),
      .iAck  (iAck[g]),
      .iCount(count_q),
      .oHold (hold[g]),
      .oRdy  (oRdy[g]),
      .oOvr  (oOvr[g])
    );
  end

  always_comb begin
    oData = '0;
    for (int i = 0; i < pCHANNELS; i++) begin
      if (32'(iSel) == i) oData = hold[i];
    end
  end

  assign oCount = count_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: a 64-bit keep-first instance and an
// 8-bit keep-last instance share stimulus and are checked against one model.
module tb_timestamp_capture;
  import timestamp_capture_pkg::*;

  localparam int S = 2;

  logic       clk, rst_n;
  logic       iCntEn, iCntClr;
  logic [3:0] iLatch, iAck;
  logic [2:0] iSel;

  logic [63:0] a_count, a_data;
  logic [3:0]  a_rdy, a_ovr;
  logic        a_wrap;
  logic [7:0]  b_count, b_data;
  logic [3:0]  b_rdy, b_ovr;
  logic        b_wrap;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  timestamp_capture #(
    .pWIDTH(64), .pCHANNELS(4), .pSYNC_STAGES(S), .pOVERWRITE(KEEP_FIRST), .SEL_W(3)
  ) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iCntEn(iCntEn), .iCntClr(iCntClr),
    .iLatch(iLatch), .iAck(iAck), .iSel(iSel),
    .oCount(a_count), .oData(a_data), .oRdy(a_rdy), .oOvr(a_ovr), .oWrap(a_wrap)
  );

  timestamp_capture #(
    .pWIDTH(8), .pCHANNELS(4), .pSYNC_STAGES(S), .pOVERWRITE(KEEP_LAST), .SEL_W(3)
  ) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iCntEn(iCntEn), .iCntClr(iCntClr),
    .iLatch(iLatch), .iAck(iAck), .iSel(iSel),
    .oCount(b_count), .oData(b_data), .oRdy(b_rdy), .oOvr(b_ovr), .oWrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) --------
  localparam logic [63:0] MASK [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF};
  localparam bit          OVW  [2] = '{1'b0, 1'b1};

  logic [63:0] m_count [2];
  logic        m_wrap  [2];
  logic [63:0] m_hold  [2][4];
  logic [3:0]  m_rdy   [2];
  logic [3:0]  m_ovr   [2];
  logic [3:0]  samples [$];

  function automatic logic [3:0] sample_at(input int k);
    return (k < samples.size()) ? samples[k] : 4'b0000;
  endfunction

  task automatic model_reset();
    samples.delete();
    for (int d = 0; d < 2; d++) begin
      m_count[d] = '0; m_wrap[d] = 1'b0; m_rdy[d] = '0; m_ovr[d] = '0;
      for (int c = 0; c < 4; c++) m_hold[d][c] = '0;
    end
  endtask

  // A rise seen S edges ago (high then, low one edge earlier) is captured now
  // with the count that was live just before this edge.
  task automatic model_step();
    logic [3:0]  rise;
    logic [63:0] old;
    samples.push_front(iLatch);
    while (samples.size() > S + 2) void'(samples.pop_back());
    rise = sample_at(S) & ~sample_at(S + 1);
    for (int d = 0; d < 2; d++) begin
      old = m_count[d];
      for (int c = 0; c < 4; c++) begin
        if (rise[c] && iAck[c]) begin
          m_hold[d][c] = old; m_rdy[d][c] = 1'b1; m_ovr[d][c] = 1'b0;
        end else if (iAck[c]) begin
          m_rdy[d][c] = 1'b0; m_ovr[d][c] = 1'b0;
        end else if (rise[c] && !m_rdy[d][c]) begin
          m_hold[d][c] = old; m_rdy[d][c] = 1'b1;
        end else if (rise[c]) begin
          m_ovr[d][c] = 1'b1;
          if (OVW[d]) m_hold[d][c] = old;
        end
      end
      if (iCntClr) begin
        m_count[d] = '0; m_wrap[d] = 1'b0;
      end else if (iCntEn) begin
        if (old == MASK[d]) m_wrap[d] = 1'b1;
        m_count[d] = (old + 64'd1) & MASK[d];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [63:0] c_act [2], d_act [2];
    logic [3:0]  r_act [2], o_act [2];
    logic        w_act [2];
    logic [63:0] exp_data;
    string       tag;
    c_act[0] = a_count; d_act[0] = a_data; r_act[0] = a_rdy; o_act[0] = a_ovr; w_act[0] = a_wrap;
    c_act[1] = 64'(b_count); d_act[1] = 64'(b_data);
    r_act[1] = b_rdy; o_act[1] = b_ovr; w_act[1] = b_wrap;
    for (int d = 0; d < 2; d++) begin
      tag      = (d == 0) ? "a" : "b";
      exp_data = (int'(iSel) < 4) ? m_hold[d][int'(iSel)] : 64'd0;
      check({tag, ".count"}, c_act[d], m_count[d]);
      check({tag, ".wrap"},  64'(w_act[d]), 64'(m_wrap[d]));
      check({tag, ".rdy"},   64'(r_act[d]), 64'(m_rdy[d]));
      check({tag, ".ovr"},   64'(o_act[d]), 64'(m_ovr[d]));
      check({tag, ".data"},  d_act[d], exp_data);
    end
  endtask

  always @(negedge clk) compare_all();

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_edges++;
    end
  endtask

  // ---------------- directed stimulus -------------------------------------
  logic [63:0] exp_v;

  initial begin
    rst_n = 1'b0; iCntEn = 1'b0; iCntClr = 1'b0;
    iLatch = '0; iAck = '0; iSel = '0;
    #22;
    check("reset.a_count", a_count, 64'd0);
    check("reset.b_rdy", 64'(b_rdy), 64'd0);
    iCntEn = 1'b1;
    rst_n  = 1'b1;
    n_edges = 0;

    // 1: rise before the edge that makes count 100 -> timestamp 101
    tick(99);
    iLatch[0] = 1'b1;
    tick(3);
    check("t1.a_rdy0", 64'(a_rdy[0]), 64'd1);
    check("t1.a_data", a_data, 64'd101);
    check("t1.b_data", 64'(b_data), 64'd101);
    check("t1.a_ovr0", 64'(a_ovr[0]), 64'd0);

    // 2: second rise while ready -> overrun; keep-first vs keep-last
    iLatch[0] = 1'b0;
    tick(2);
    iLatch[0] = 1'b1;
    tick(3);
    check("t2.a_ovr0", 64'(a_ovr[0]), 64'd1);
    check("t2.a_data_kept", a_data, 64'd101);
    check("t2.b_data_new", 64'(b_data), 64'd106);
    iAck[0] = 1'b1;
    tick();
    iAck[0] = 1'b0;
    check("t2.a_rdy_ack", 64'(a_rdy[0]), 64'd0);
    check("t2.b_ovr_ack", 64'(b_ovr[0]), 64'd0);
    tick(4);
    check("t2.held_no_retrig", 64'(a_rdy[0]), 64'd0);
    iLatch[0] = 1'b0;

    // 3: ack coinciding with a detected edge on a ready, overrun channel
    iSel = 3'd1;
    iLatch[1] = 1'b1; tick(3);
    iLatch[1] = 1'b0; tick(2);
    iLatch[1] = 1'b1; tick(3);
    check("t3.a_ovr1_set", 64'(a_ovr[1]), 64'd1);
    iLatch[1] = 1'b0; tick(2);
    iLatch[1] = 1'b1; tick(2);
    iAck[1] = 1'b1;
    exp_v = 64'(n_edges);
    tick();
    iAck[1] = 1'b0;
    check("t3.a_rdy1", 64'(a_rdy[1]), 64'd1);
    check("t3.a_ovr1", 64'(a_ovr[1]), 64'd0);
    check("t3.a_data1", a_data, exp_v);
    iLatch[1] = 1'b0;

    // 4: wrap on the 8-bit timebase, clear, clear with enable, capture on clear
    iCntClr = 1'b1; tick(); iCntClr = 1'b0;
    check("t4.a_cleared", a_count, 64'd0);
    tick(254);
    check("t4.b_254", 64'(b_count), 64'd254);
    check("t4.b_nowrap", 64'(b_wrap), 64'd0);
    tick(2);
    check("t4.b_wrapped_cnt", 64'(b_count), 64'd0);
    check("t4.b_wrap", 64'(b_wrap), 64'd1);
    check("t4.a_256", a_count, 64'd256);
    check("t4.a_nowrap", 64'(a_wrap), 64'd0);
    iSel = 3'd3;
    iLatch[3] = 1'b1;
    tick(2);
    iCntClr = 1'b1;
    tick();
    check("t4.clr_cnt", a_count, 64'd0);
    check("t4.clr_wrap", 64'(b_wrap), 64'd0);
    check("t4.a_preclear", a_data, 64'd258);
    check("t4.b_preclear", 64'(b_data), 64'd2);
    tick();
    iCntClr = 1'b0;
    check("t4.clr_and_en", a_count, 64'd0);
    iCntEn = 1'b0;
    tick(3);
    check("t4.en_low_hold", 64'(b_count), 64'd0);
    iCntEn = 1'b1;

    // 5: simultaneous rises on all channels; out-of-range select
    iAck = 4'hF; iLatch = 4'h0;
    tick();
    iAck = 4'h0;
    tick(3);
    iCntClr = 1'b1; iLatch = 4'hF;
    tick();
    iCntClr = 1'b0;
    tick(2);
    check("t5.a_rdy_all", 64'(a_rdy), 64'hF);
    check("t5.b_rdy_all", 64'(b_rdy), 64'hF);
    for (int c = 0; c < 4; c++) begin
      iSel = 3'(c);
      #1;
      check($sformatf("t5.a_hold%0d", c), a_data, 64'd1);
      check($sformatf("t5.b_hold%0d", c), 64'(b_data), 64'd1);
    end
    iSel = 3'd5; #1;
    check("t5.a_sel5", a_data, 64'd0);
    iSel = 3'd7; #1;
    check("t5.b_sel7", 64'(b_data), 64'd0);
    iSel = 3'd0;
    tick();

    // 6: asynchronous reset mid-cycle; input held high through release
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.a_count_rst", a_count, 64'd0);
    check("t6.a_rdy_rst", 64'(a_rdy), 64'd0);
    check("t6.a_data_rst", a_data, 64'd0);
    check("t6.b_wrap_rst", 64'(b_wrap), 64'd0);
    check("t6.b_ovr_rst", 64'(b_ovr), 64'd0);
    iLatch = 4'b0100;
    iSel   = 3'd2;
    #10;
    @(negedge clk);
    rst_n   = 1'b1;
    n_edges = 0;
    tick(3);
    check("t6.one_capture", 64'(a_rdy), 64'b0100);
    check("t6.cap_value", a_data, 64'd2);
    tick(10);
    check("t6.no_retrig_rdy", 64'(b_rdy), 64'b0100);
    check("t6.no_retrig_ovr", 64'(a_ovr), 64'd0);
    iLatch = 4'b0000;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
